total_zeros_ctrl: RTL and testbench
===================================

# total_zeros_ctrl

Sequencer for the total_zeros stage of the CAVLC residual decoder. Once coeff_token has been decoded, it takes TotalCoeff and maxNumCoeff for one block and decides whether total_zeros is present. When it is, it waits for a valid 9-bit MSB-first bitstream window and looks the code up in the chroma-DC or luma total_zeros table. It then asks the bitstream shifter to consume the code length and returns TotalZeroes to the run_before stage.

## Interface
Parameters:
- None. Window width is fixed at 9 bits, the longest total_zeros code.

Ports:
- Clk  in  1  clock. One clock domain; reset is asynchronous and active-high.
- Rst  in  1  asynchronous, active-high reset.
- Start  in  1  single-cycle request. Accepted only when Ready=1.
- Ready  out  1  high in IDLE only.
- TotalCoeffIn  in  5  0..16, sampled when Start is accepted.
- MaxNumCoeff  in  5  4 = chroma DC; 15 or 16 = luma/AC. Sampled when Start is accepted.
- BitsValid  in  1  Bits holds the next unread stream bits.
- Bits  in  9  bitstream window; Bits[8] is the next bit.
- ShiftReq  out  1  request to consume ShiftAmt bits.
- ShiftAmt  out  4  1..9; valid while ShiftReq=1.
- ShiftAck  in  1  shifter accepted the request (sampled while ShiftReq=1).
- TotalZeroes  out  4  result. Valid with Done and held until the next accepted Start.
- Done  out  1  single-cycle completion pulse.
- Error  out  1  single-cycle pulse: no code matched, or illegal MaxNumCoeff.

## Operation
FSM states: IDLE, WAIT_BITS, SHIFT, DONE, ERR.

- IDLE
  - Start latches TotalCoeffIn and MaxNumCoeff.
  - MaxNumCoeff not in {4, 15, 16} -> ERR.
  - TotalCoeff == 0, or TotalCoeff >= MaxNumCoeff -> DONE with TotalZeroes=0; no bits consumed.
  - Otherwise -> WAIT_BITS.
- WAIT_BITS
  - Stay while BitsValid=0.
  - When BitsValid=1, run the lookup: chroma-DC table if latched MaxNumCoeff == 4, else luma table. Inputs are latched TotalCoeff and Bits.
  - Lookup NumShift == 0 -> ERR.
  - Else register TotalZeroes and ShiftAmt=NumShift -> SHIFT.
- SHIFT
  - ShiftReq=1 with ShiftAmt held stable.
  - Bits and BitsValid are ignored.
  - On ShiftAck -> DONE. Without ack, stay indefinitely; ShiftReq is never withdrawn.
- DONE: Done=1 for one cycle -> IDLE.
- ERR: Error=1 for one cycle, TotalZeroes forced to 0 -> IDLE. The decoder above handles resync.

Other rules:
- Start while Ready=0 is ignored; no queueing.
- Chroma-DC codes:
  - TotalCoeff 1: 1 -> 0, 01 -> 1, 001 -> 2, 000 -> 3.
  - TotalCoeff 2: 1 -> 0, 01 -> 1, 00 -> 2.
  - TotalCoeff 3: 1 -> 0, 0 -> 1.
- Luma codes follow the H.264 4x4 total_zeros table for TotalCoeff 1..15, up to 9 bits, values 0..15.

## Timing
- Reset (async, any state): FSM -> IDLE. TotalZeroes=0, ShiftAmt=0, ShiftReq=0, Done=0, Error=0. Ready=1, since it is decoded from IDLE.
- ShiftReq, ShiftAmt, Done, Error and TotalZeroes are registered. Ready is combinational from state.
- Start accepted at cycle 0:
  - Skip path: Done at cycle 1.
  - Coded path with BitsValid high at cycle 1 and ShiftAck at cycle 2: ShiftReq cycle 2, Done cycle 3.
  - Each cycle without BitsValid or ShiftAck adds one cycle.
- Back-to-back requests: Ready returns the cycle after Done, so the minimum spacing between accepted Starts is 4 cycles (coded) or 2 cycles (skip).
- Reset during SHIFT drops ShiftReq immediately. The shifter treats an unacknowledged request as void.

## Structure
- Shared CAVLC package:
  - state encoding enum;
  - constants MAXNC_CHROMA_DC=4, MAXNC_LUMA_AC=15, MAXNC_LUMA=16;
  - ZW_BITS=9.
- Leaf lookups:
  - the existing chroma-DC total_zeros table;
  - one new combinational sub-module, total_zeros_luma_table, with the same port shape: Bits[8:0], TotalCoeff[3:0] -> TotalZeroes, NumShift; NumShift=0 means no match.
- The controller muxes between the two tables and owns all state.

## Test plan
- Chroma DC (Max=4), TC=1, Bits=9'b001_000000, BitsValid high, ShiftAck immediate -> ShiftReq with ShiftAmt=3; Done at cycle 3 with TotalZeroes=2.
- Chroma DC, TC=3, Bits=9'b0_xxxxxxxx -> ShiftAmt=1, TotalZeroes=1. Then TC=4, Max=4 -> Done at cycle 1, TotalZeroes=0, ShiftReq never asserted.
- Luma (Max=16), TC=1, Bits=9'b000000001 -> ShiftAmt=9, TotalZeroes=15. Hold BitsValid low 3 cycles, then ShiftAck low 2 cycles -> Done at cycle 8, ShiftAmt stable throughout.
- MaxNumCoeff=7 -> Error at cycle 1, no ShiftReq. Start pulsed during SHIFT -> ignored, latched TC unchanged.
- Rst asserted mid-SHIFT -> ShiftReq=0 in the same cycle, Ready=1. A fresh Start after release completes normally.
- TC=0 with any Max -> Done, TotalZeroes=0. Luma TC=15, Max=15 -> skip path, TotalZeroes=0.

Source files
------------

// File: rtl/total_zeros_ctrl_pkg.sv
// Shared CAVLC total_zeros definitions: FSM state encoding, MaxNumCoeff codes, window width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package total_zeros_ctrl_pkg;

    localparam int         ZW_BITS         = 9;
    localparam logic [4:0] MAXNC_CHROMA_DC = 5'd4;
    localparam logic [4:0] MAXNC_LUMA_AC   = 5'd15;
    localparam logic [4:0] MAXNC_LUMA      = 5'd16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_BITS,
        ST_SHIFT,
        ST_DONE,
        ST_ERR
    } state_t;

    function automatic logic maxnc_legal(input logic [4:0] m);
        return (m == MAXNC_CHROMA_DC) || (m == MAXNC_LUMA_AC) || (m == MAXNC_LUMA);
    endfunction

endpackage

// File: rtl/total_zeros_ctrl_if.sv
// Request/bitstream/shifter/result bundle between the CAVLC decoder and total_zeros_ctrl.
// Latency: wires only.
// Backpressure: start gated by ready; bits gated by bits_vld; shift_req held until shift_ack.
interface total_zeros_ctrl_if;
    import total_zeros_ctrl_pkg::*;

    logic               start;
    logic               ready;
    logic [4:0]         total_coeff;
    logic [4:0]         max_num_coeff;
    logic               bits_vld;
    logic [ZW_BITS-1:0] bits_dat;      // bits_dat[8] is the next unread bit
    logic               shift_req;
    logic [3:0]         shift_amt;
    logic               shift_ack;
    logic [3:0]         total_zeroes;
    logic               done;
    logic               error;

    // master: decoder/shifter side; slave: the controller
    modport master (
        output start, total_coeff, max_num_coeff, bits_vld, bits_dat, shift_ack,
        input  ready, shift_req, shift_amt, total_zeroes, done, error
    );
    modport slave (
        input  start, total_coeff, max_num_coeff, bits_vld, bits_dat, shift_ack,
        output ready, shift_req, shift_amt, total_zeroes, done, error
    );
endinterface

// File: rtl/total_zeros_chroma_dc_table.sv
// Chroma-DC total_zeros code lookup. Ports: bits_i window (MSB first), total_coeff_i 1..3 -> total_zeroes_o, num_shift_o.
// Latency: combinational.
// Backpressure: none; num_shift_o == 0 means no code matched.
module total_zeros_chroma_dc_table
    import total_zeros_ctrl_pkg::*;
(
    input  logic [ZW_BITS-1:0] bits_i,
    input  logic [3:0]         total_coeff_i,
    output logic [3:0]         total_zeroes_o,
    output logic [3:0]         num_shift_o
);
    logic [7:0] r;  // {total_zeroes, num_shift}

    always_comb begin
        r = 8'h00;
        case (total_coeff_i)
            4'd1: casez (bits_i)
                9'b1_????????: r = 8'h01;  9'b01_???????: r = 8'h12;
                9'b001_??????: r = 8'h23;  9'b000_??????: r = 8'h33;
                default:       r = 8'h00;
            endcase
            4'd2: casez (bits_i)
                9'b1_????????: r = 8'h01;  9'b01_???????: r = 8'h12;
                9'b00_???????: r = 8'h22;
                default:       r = 8'h00;
            endcase
            4'd3: casez (bits_i)
                9'b1_????????: r = 8'h01;  9'b0_????????: r = 8'h11;
                default:       r = 8'h00;
            endcase
            default: r = 8'h00;
        endcase
    end

    assign total_zeroes_o = r[7:4];
    assign num_shift_o    = r[3:0];
endmodule

// File: rtl/total_zeros_luma_table.sv
// Luma/AC 4x4 total_zeros code lookup. Ports: bits_i window (MSB first), total_coeff_i 1..15 -> total_zeroes_o, num_shift_o.
// Latency: combinational.
// Backpressure: none; num_shift_o == 0 means no code matched.
module total_zeros_luma_table
    import total_zeros_ctrl_pkg::*;
(
    input  logic [ZW_BITS-1:0] bits_i,
    input  logic [3:0]         total_coeff_i,
    output logic [3:0]         total_zeroes_o,
    output logic [3:0]         num_shift_o
);
    logic [7:0] r;  // {total_zeroes, num_shift}

    always_comb begin
        r = 8'h00;
        case (total_coeff_i)
            4'd1: casez (bits_i)
                9'b1_????????: r = 8'h01; 9'b011_??????: r = 8'h13; 9'b010_??????: r = 8'h23;
                9'b0011_?????: r = 8'h34; 9'b0010_?????: r = 8'h44; 9'b00011_????: r = 8'h55;
                9'b00010_????: r = 8'h65; 9'b000011_???: r = 8'h76; 9'b000010_???: r = 8'h86;
                9'b0000011_??: r = 8'h97; 9'b0000010_??: r = 8'hA7; 9'b00000011_?: r = 8'hB8;
                9'b00000010_?: r = 8'hC8; 9'b000000011: r = 8'hD9;   9'b000000010: r = 8'hE9;
                9'b000000001: r = 8'hF9;  default: r = 8'h00;
            endcase
            4'd2: casez (bits_i)
                9'b111_??????: r = 8'h03; 9'b110_??????: r = 8'h13; 9'b101_??????: r = 8'h23;
                9'b100_??????: r = 8'h33; 9'b011_??????: r = 8'h43; 9'b0101_?????: r = 8'h54;
                9'b0100_?????: r = 8'h64; 9'b0011_?????: r = 8'h74; 9'b0010_?????: r = 8'h84;
                9'b00011_????: r = 8'h95; 9'b00010_????: r = 8'hA5; 9'b000011_???: r = 8'hB6;
                9'b000010_???: r = 8'hC6; 9'b000001_???: r = 8'hD6; 9'b000000_???: r = 8'hE6;
                default: r = 8'h00;
            endcase
            4'd3: casez (bits_i)
                9'b0101_?????: r = 8'h04; 9'b111_??????: r = 8'h13; 9'b110_??????: r = 8'h23;
                9'b101_??????: r = 8'h33; 9'b0100_?????: r = 8'h44; 9'b0011_?????: r = 8'h54;
                9'b100_??????: r = 8'h63; 9'b011_??????: r = 8'h73; 9'b0010_?????: r = 8'h84;
                9'b00011_????: r = 8'h95; 9'b00010_????: r = 8'hA5; 9'b000001_???: r = 8'hB6;
                9'b00001_????: r = 8'hC5; 9'b000000_???: r = 8'hD6; default: r = 8'h00;
            endcase
            4'd4: casez (bits_i)
                9'b00011_????: r = 8'h05; 9'b111_??????: r = 8'h13; 9'b0101_?????: r = 8'h24;
                9'b0100_?????: r = 8'h34; 9'b110_??????: r = 8'h43; 9'b101_??????: r = 8'h53;
                9'b100_??????: r = 8'h63; 9'b0011_?????: r = 8'h74; 9'b011_??????: r = 8'h83;
                9'b0010_?????: r = 8'h94; 9'b00010_????: r = 8'hA5; 9'b00001_????: r = 8'hB5;
                9'b00000_????: r = 8'hC5; default: r = 8'h00;
            endcase
            4'd5: casez (bits_i)
                9'b0101_?????: r = 8'h04; 9'b0100_?????: r = 8'h14; 9'b0011_?????: r = 8'h24;
                9'b111_??????: r = 8'h33; 9'b110_??????: r = 8'h43; 9'b101_??????: r = 8'h53;
                9'b100_??????: r = 8'h63; 9'b011_??????: r = 8'h73; 9'b0010_?????: r = 8'h84;
                9'b00001_????: r = 8'h95; 9'b0001_?????: r = 8'hA4; 9'b00000_????: r = 8'hB5;
                default: r = 8'h00;
            endcase
            4'd6: casez (bits_i)
                9'b000001_???: r = 8'h06; 9'b00001_????: r = 8'h15; 9'b111_??????: r = 8'h23;
                9'b110_??????: r = 8'h33; 9'b101_??????: r = 8'h43; 9'b100_??????: r = 8'h53;
                9'b011_??????: r = 8'h63; 9'b010_??????: r = 8'h73; 9'b0001_?????: r = 8'h84;
                9'b001_??????: r = 8'h93; 9'b000000_???: r = 8'hA6; default: r = 8'h00;
            endcase
            4'd7: casez (bits_i)
                9'b000001_???: r = 8'h06; 9'b00001_????: r = 8'h15; 9'b101_??????: r = 8'h23;
                9'b100_??????: r = 8'h33; 9'b011_??????: r = 8'h43; 9'b11_???????: r = 8'h52;
                9'b010_??????: r = 8'h63; 9'b0001_?????: r = 8'h74; 9'b001_??????: r = 8'h83;
                9'b000000_???: r = 8'h96; default: r = 8'h00;
            endcase
            4'd8: casez (bits_i)
                9'b000001_???: r = 8'h06; 9'b0001_?????: r = 8'h14; 9'b00001_????: r = 8'h25;
                9'b011_??????: r = 8'h33; 9'b11_???????: r = 8'h42; 9'b10_???????: r = 8'h52;
                9'b010_??????: r = 8'h63; 9'b001_??????: r = 8'h73; 9'b000000_???: r = 8'h86;
                default: r = 8'h00;
            endcase
            4'd9: casez (bits_i)
                9'b000001_???: r = 8'h06; 9'b000000_???: r = 8'h16; 9'b0001_?????: r = 8'h24;
                9'b11_???????: r = 8'h32; 9'b10_???????: r = 8'h42; 9'b001_??????: r = 8'h53;
                9'b01_???????: r = 8'h62; 9'b00001_????: r = 8'h75; default: r = 8'h00;
            endcase
            4'd10: casez (bits_i)
                9'b00001_????: r = 8'h05; 9'b00000_????: r = 8'h15; 9'b001_??????: r = 8'h23;
                9'b11_???????: r = 8'h32; 9'b10_???????: r = 8'h42; 9'b01_???????: r = 8'h52;
                9'b0001_?????: r = 8'h64; default: r = 8'h00;
            endcase
            4'd11: casez (bits_i)
                9'b0000_?????: r = 8'h04; 9'b0001_?????: r = 8'h14; 9'b001_??????: r = 8'h23;
                9'b010_??????: r = 8'h33; 9'b1_????????: r = 8'h41; 9'b011_??????: r = 8'h53;
                default: r = 8'h00;
            endcase
            4'd12: casez (bits_i)
                9'b0000_?????: r = 8'h04; 9'b0001_?????: r = 8'h14; 9'b01_???????: r = 8'h22;
                9'b1_????????: r = 8'h31; 9'b001_??????: r = 8'h43; default: r = 8'h00;
            endcase
            4'd13: casez (bits_i)
                9'b000_??????: r = 8'h03; 9'b001_??????: r = 8'h13; 9'b1_????????: r = 8'h21;
                9'b01_???????: r = 8'h32; default: r = 8'h00;
            endcase
            4'd14: casez (bits_i)
                9'b00_???????: r = 8'h02; 9'b01_???????: r = 8'h12; 9'b1_????????: r = 8'h21;
                default: r = 8'h00;
            endcase
            4'd15: casez (bits_i)
                9'b0_????????: r = 8'h01; 9'b1_????????: r = 8'h11; default: r = 8'h00;
            endcase
            default: r = 8'h00;
        endcase
    end

    assign total_zeroes_o = r[7:4];
    assign num_shift_o    = r[3:0];
endmodule

// File: rtl/total_zeros_ctrl.sv
// total_zeros sequencer: decide presence, look up code, request shift, return TotalZeroes. Ports: clk_i, rst_i, bus (slave).
// Latency: skip/error 1 cycle after Start; coded path 3 cycles plus one per cycle without bits_vld or shift_ack.
// Backpressure: Start taken only when ready (IDLE); waits on bits_vld; shift_req held until shift_ack.
module total_zeros_ctrl
    import total_zeros_ctrl_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    total_zeros_ctrl_if.slave bus
);
    state_t     state_q;
    logic [4:0] tc_q;
    logic [4:0] maxnc_q;
    logic       shift_req_q;
    logic [3:0] shift_amt_q;
    logic [3:0] tz_q;
    logic       done_q;
    logic       error_q;

    logic [3:0] cdc_tz, cdc_len, luma_tz, luma_len, lk_tz, lk_len;

    // Both tables only ever see tc in 1..15 when consulted: the skip test
    // in IDLE removes 0 and anything >= MaxNumCoeff.
    total_zeros_chroma_dc_table u_chroma (
        .bits_i         (bus.bits_dat),
        .total_coeff_i  (tc_q[3:0]),
        .total_zeroes_o (cdc_tz),
        .num_shift_o    (cdc_len)
    );

    total_zeros_luma_table u_luma (
        .bits_i         (bus.bits_dat),
        .total_coeff_i  (tc_q[3:0]),
        .total_zeroes_o (luma_tz),
        .num_shift_o    (luma_len)
    );

    assign lk_tz  = (maxnc_q == MAXNC_CHROMA_DC) ? cdc_tz  : luma_tz;
    assign lk_len = (maxnc_q == MAXNC_CHROMA_DC) ? cdc_len : luma_len;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            tc_q        <= '0;
            maxnc_q     <= '0;
            shift_req_q <= 1'b0;
            shift_amt_q <= '0;
            tz_q        <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        tc_q    <= bus.total_coeff;
                        maxnc_q <= bus.max_num_coeff;
                        if (!maxnc_legal(bus.max_num_coeff)) begin
                            state_q <= ST_ERR;
                            error_q <= 1'b1;
                            tz_q    <= '0;
                        end else if ((bus.total_coeff == 5'd0) ||
                                     (bus.total_coeff >= bus.max_num_coeff)) begin
                            // Block full or empty: total_zeros is not coded.
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            tz_q    <= '0;
                        end else begin
                            state_q <= ST_WAIT_BITS;
                        end
                    end
                end
                ST_WAIT_BITS: begin
                    if (bus.bits_vld) begin
                        if (lk_len == 4'd0) begin
                            state_q <= ST_ERR;
                            error_q <= 1'b1;
                            tz_q    <= '0;
                        end else begin
                            state_q     <= ST_SHIFT;
                            tz_q        <= lk_tz;
                            shift_amt_q <= lk_len;
                            shift_req_q <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (bus.shift_ack) begin
                        state_q     <= ST_DONE;
                        shift_req_q <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                ST_ERR:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.ready        = (state_q == ST_IDLE);
    assign bus.shift_req    = shift_req_q;
    assign bus.shift_amt    = shift_amt_q;
    assign bus.total_zeroes = tz_q;
    assign bus.done         = done_q;
    assign bus.error        = error_q;
endmodule

// File: tb/tb_total_zeros_ctrl.sv
// Directed, table-driven bench for total_zeros_ctrl with per-cycle expected outputs.
// Latency: checks the exact cycle of ShiftReq, Done and Error for each vector.
// Backpressure: stalls BitsValid and ShiftAck per vector, pokes Start while busy.
module tb_total_zeros_ctrl;
    localparam int K_SKIP = 0;  // no bits consumed, Done at cycle 1
    localparam int K_ERR  = 1;  // illegal MaxNumCoeff, Error at cycle 1
    localparam int K_COD  = 2;  // coded path
    localparam int K_ELU  = 3;  // lookup miss, Error after bits arrive

    typedef struct {
        logic [4:0] maxnc;
        logic [4:0] tc;
        logic [8:0] bits;
        int         bw;     // cycles BitsValid held low in WAIT_BITS
        int         aw;     // cycles ShiftAck held low in SHIFT
        int         kind;
        int         amt;
        int         tz;
        bit         poke;   // pulse Start during the first SHIFT cycle
    } vec_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   cur;
    vec_t vecs[24];

    total_zeros_ctrl_if bus();

    total_zeros_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic vec_t mk(input logic [4:0] m, input logic [4:0] t, input logic [8:0] b,
                                input int bw, input int aw, input int k, input int a,
                                input int z, input bit p);
        vec_t v;
        v.maxnc = m; v.tc = t; v.bits = b; v.bw = bw; v.aw = aw;
        v.kind = k; v.amt = a; v.tz = z; v.poke = p;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s (vec %0d): got %0d, expected %0d", name, cur, act, exp);
        end
    endtask

    // Called right after a falling edge; returns at the falling edge where Ready is back.
    task automatic run_txn(input vec_t v);
        int  fin;
        bit  exp_req;
        case (v.kind)
            K_COD:   fin = v.bw + v.aw + 3;
            K_ELU:   fin = v.bw + 2;
            default: fin = 1;
        endcase
        chk("ready_before_start", int'(bus.ready), 1);
        bus.start         = 1'b1;
        bus.total_coeff   = v.tc;
        bus.max_num_coeff = v.maxnc;
        bus.bits_dat      = v.bits;
        bus.bits_vld      = 1'b0;
        bus.shift_ack     = 1'b0;
        for (int c = 1; c <= fin + 1; c++) begin
            @(negedge clk);
            exp_req = (v.kind == K_COD) && (c >= v.bw + 2) && (c <= v.bw + 2 + v.aw);
            chk("shift_req", int'(bus.shift_req), int'(exp_req));
            if (exp_req) chk("shift_amt", int'(bus.shift_amt), v.amt);
            chk("done", int'(bus.done),
                int'((c == fin) && (v.kind == K_SKIP || v.kind == K_COD)));
            chk("error", int'(bus.error),
                int'((c == fin) && (v.kind == K_ERR || v.kind == K_ELU)));
            chk("ready", int'(bus.ready), int'(c > fin));
            if (c == fin) chk("total_zeroes", int'(bus.total_zeroes), v.tz);
            bus.start     = v.poke && (c == v.bw + 2);
            if (bus.start) begin
                bus.total_coeff   = 5'd2;
                bus.max_num_coeff = 5'd4;
            end
            bus.bits_vld  = (c > v.bw);
            bus.shift_ack = (c >= v.bw + 2 + v.aw);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cur   = -1;
        rst   = 1'b1;
        bus.start = 1'b0; bus.total_coeff = '0; bus.max_num_coeff = '0;
        bus.bits_vld = 1'b0; bus.bits_dat = '0; bus.shift_ack = 1'b0;

        vecs[0]  = mk(5'd4,  5'd1,  9'b001000000, 0, 0, K_COD, 3, 2, 0);
        vecs[1]  = mk(5'd4,  5'd3,  9'b011111111, 0, 0, K_COD, 1, 1, 0);
        vecs[2]  = mk(5'd4,  5'd4,  9'b000000000, 0, 0, K_SKIP, 0, 0, 0);
        vecs[3]  = mk(5'd16, 5'd1,  9'b000000001, 3, 2, K_COD, 9, 15, 1);
        vecs[4]  = mk(5'd7,  5'd3,  9'b100000000, 0, 0, K_ERR, 0, 0, 0);
        vecs[5]  = mk(5'd16, 5'd0,  9'b111111111, 0, 0, K_SKIP, 0, 0, 0);
        vecs[6]  = mk(5'd4,  5'd0,  9'b111111111, 0, 0, K_SKIP, 0, 0, 0);
        vecs[7]  = mk(5'd15, 5'd15, 9'b000000000, 0, 0, K_SKIP, 0, 0, 0);
        vecs[8]  = mk(5'd16, 5'd1,  9'b000000000, 1, 0, K_ELU, 0, 0, 0);
        vecs[9]  = mk(5'd16, 5'd2,  9'b000000111, 0, 0, K_COD, 6, 14, 0);
        vecs[10] = mk(5'd16, 5'd3,  9'b010111111, 0, 0, K_COD, 4, 0, 0);
        vecs[11] = mk(5'd16, 5'd7,  9'b110000000, 0, 0, K_COD, 2, 5, 0);
        vecs[12] = mk(5'd16, 5'd11, 9'b100000000, 0, 0, K_COD, 1, 4, 0);
        vecs[13] = mk(5'd15, 5'd14, 9'b011111111, 0, 0, K_COD, 2, 1, 0);
        vecs[14] = mk(5'd4,  5'd2,  9'b001111111, 0, 1, K_COD, 2, 2, 0);
        vecs[15] = mk(5'd16, 5'd9,  9'b000010000, 0, 0, K_COD, 5, 7, 0);
        vecs[16] = mk(5'd4,  5'd1,  9'b000111111, 0, 0, K_COD, 3, 3, 0);
        vecs[17] = mk(5'd16, 5'd6,  9'b001000000, 0, 0, K_COD, 3, 9, 0);
        vecs[18] = mk(5'd16, 5'd8,  9'b000000111, 2, 0, K_COD, 6, 8, 0);
        vecs[19] = mk(5'd16, 5'd4,  9'b000111111, 0, 0, K_COD, 5, 0, 0);
        vecs[20] = mk(5'd16, 5'd16, 9'b000000000, 0, 0, K_SKIP, 0, 0, 0);
        vecs[21] = mk(5'd4,  5'd5,  9'b000000000, 0, 0, K_SKIP, 0, 0, 0);
        vecs[22] = mk(5'd0,  5'd0,  9'b000000000, 0, 0, K_ERR, 0, 0, 0);
        vecs[23] = mk(5'd15, 5'd1,  9'b011000000, 0, 0, K_COD, 3, 1, 0);

        // Reset state while reset is held
        #3;
        chk("rst_ready", int'(bus.ready), 1);
        chk("rst_shift_req", int'(bus.shift_req), 0);
        chk("rst_shift_amt", int'(bus.shift_amt), 0);
        chk("rst_total_zeroes", int'(bus.total_zeroes), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_error", int'(bus.error), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            cur = i;
            run_txn(vecs[i]);
        end

        // Reset asserted while a shift request is outstanding
        cur = 100;
        bus.start = 1'b1; bus.total_coeff = 5'd5; bus.max_num_coeff = 5'd16;
        bus.bits_dat = 9'b111000000; bus.bits_vld = 1'b1; bus.shift_ack = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("pre_rst_shift_req", int'(bus.shift_req), 1);
        chk("pre_rst_shift_amt", int'(bus.shift_amt), 3);
        chk("pre_rst_total_zeroes", int'(bus.total_zeroes), 3);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_shift_req", int'(bus.shift_req), 0);
        chk("mid_rst_ready", int'(bus.ready), 1);
        chk("mid_rst_total_zeroes", int'(bus.total_zeroes), 0);
        @(negedge clk);
        rst = 1'b0;
        cur = 101;
        run_txn(vecs[0]);
        cur = 102;
        run_txn(vecs[11]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
